// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller for the 5-stage LEGv8 pipeline: load-use stalls,
// slow data-memory hold, taken-branch flushes and saturating stall/flush counters.
module decode_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int ZERO_REG = 31,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_r2,
  input  logic                id_uses_rn,
  input  logic                id_uses_r2,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                mem_br_taken,
  input  logic                dmem_busy,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                idex_bubble,
  output logic                pipe_hold,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic                exmem_flush,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  typedef enum logic {RUN, LU_WAIT} state_t;

  localparam logic [REG_BITS-1:0] ZERO    = REG_BITS'(ZERO_REG);
  localparam logic [3:0]          LU_INIT = 4'(LU_STALL - 1);

  state_t     state, state_nxt;
  logic [3:0] lu_cnt, lu_cnt_nxt;
  logic       lu_hit;
  logic       flush_evt;

  always_comb begin
    lu_hit = ex_valid && ex_mem_read && id_valid && (ex_rd != ZERO) &&
             ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_r2 && (id_r2 == ex_rd)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    if (dmem_busy) begin
      state_nxt  = state;
    end else if (mem_br_taken) begin
      state_nxt  = RUN;
      lu_cnt_nxt = '0;
    end else if (state == LU_WAIT) begin
      lu_cnt_nxt = lu_cnt - 4'd1;
      if (lu_cnt_nxt == 4'd0) state_nxt = RUN;
    end else if (lu_hit && (LU_STALL > 1)) begin
      state_nxt  = LU_WAIT;
      lu_cnt_nxt = LU_INIT;
    end
  end

  // Mealy outputs; everything is forced low while reset is asserted.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst_n) begin
      if (dmem_busy) begin
        pipe_hold = 1'b1;
      end else if (mem_br_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if ((state == LU_WAIT) || lu_hit) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  assign flush_evt = !dmem_busy && mem_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench: two instances (LU_STALL=1 with 4-bit counters, LU_STALL=3 with
// 16-bit counters) share stimulus and are compared with a bubble-count reference model.
module tb_decode_hazard_ctrl;

  localparam int LS_A = 1, CW_A = 4;
  localparam int LS_B = 3, CW_B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_uses_rn, id_uses_r2, ex_valid, ex_mem_read, mem_br_taken, dmem_busy;
  logic [4:0] id_rn, id_r2, ex_rd;

  logic a_pc, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf;
  logic b_pc, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf;
  logic [CW_A-1:0] a_stall, a_flush;
  logic [CW_B-1:0] b_stall, b_flush;

  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed, and plain integer counters.
  int rem_a, rem_b, sc_a, sc_b, fc_a, fc_b;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.REG_BITS(5), .ZERO_REG(31), .LU_STALL(LS_A), .CNT_W(CW_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_r2(id_r2),
    .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_br_taken(mem_br_taken),
    .dmem_busy(dmem_busy), .pc_write(a_pc), .ifid_write(a_ifw), .idex_bubble(a_bub),
    .pipe_hold(a_hold), .ifid_flush(a_iff), .idex_flush(a_idf), .exmem_flush(a_exf),
    .stall_cnt(a_stall), .flush_cnt(a_flush));

  decode_hazard_ctrl #(.REG_BITS(5), .ZERO_REG(31), .LU_STALL(LS_B), .CNT_W(CW_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_r2(id_r2),
    .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_br_taken(mem_br_taken),
    .dmem_busy(dmem_busy), .pc_write(b_pc), .ifid_write(b_ifw), .idex_bubble(b_bub),
    .pipe_hold(b_hold), .ifid_flush(b_iff), .idex_flush(b_idf), .exmem_flush(b_exf),
    .stall_cnt(b_stall), .flush_cnt(b_flush));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Load-use condition straight from the hazard rules.
  function automatic bit model_hit();
    bit rn_dep = id_uses_rn && (id_rn == ex_rd);
    bit r2_dep = id_uses_r2 && (id_r2 == ex_rd);
    return ex_valid && ex_mem_read && id_valid && (ex_rd != 5'd31) && (rn_dep || r2_dep);
  endfunction

  // Control vector {pc_write, ifid_write, idex_bubble, pipe_hold, ifid_flush, idex_flush, exmem_flush}.
  function automatic logic [6:0] model_ctl(input int rem, input bit hit);
    if (dmem_busy)          return 7'b0001000;
    if (mem_br_taken)       return 7'b1100111;
    if (rem > 0 || hit)     return 7'b0010000;
    return 7'b1100000;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic advance(input int ls, input int w, input bit hit, input logic [6:0] ctl,
                         inout int rem, inout int sc, inout int fc);
    if (!ctl[6]) sc = sat_inc(sc, w);
    if (dmem_busy) return;
    if (mem_br_taken) begin
      rem = 0;
      fc = sat_inc(fc, w);
    end else if (rem > 0) rem--;
    else if (hit) rem = ls - 1;
  endtask

  // Called just after a falling edge with inputs already driven; checks and then
  // returns at the next falling edge.
  task automatic step();
    bit hit;
    logic [6:0] ea, eb;
    #1;
    hit = model_hit();
    ea = model_ctl(rem_a, hit);
    eb = model_ctl(rem_b, hit);
    check("a_ctl", {a_pc, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, ea);
    check("b_ctl", {b_pc, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, eb);
    check("a_stall_cnt", a_stall, sc_a);
    check("a_flush_cnt", a_flush, fc_a);
    check("b_stall_cnt", b_stall, sc_b);
    check("b_flush_cnt", b_flush, fc_b);
    advance(LS_A, CW_A, hit, ea, rem_a, sc_a, fc_a);
    advance(LS_B, CW_B, hit, eb, rem_b, sc_b, fc_b);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 1'b1; id_rn = 5'd1; id_r2 = 5'd2; id_uses_rn = 1'b1; id_uses_r2 = 1'b1;
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd3; mem_br_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic load_use_rn9();
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; id_uses_rn = 1'b1;
  endtask

  // Asynchronous reset pulse, asserted between clock edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_ctl", {a_pc, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, 7'b0);
    check("rst_b_ctl", {b_pc, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, 7'b0);
    check("rst_cnts", {a_stall, a_flush, b_stall, b_flush}, 32'h0 + 0);
    rem_a = 0; rem_b = 0; sc_a = 0; sc_b = 0; fc_a = 0; fc_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    pulse_reset();

    // Load-use on rn: one bubble for A, three for B.
    load_use_rn9(); step();
    idle(); step();
    check("t1_a_stall", a_stall, 1);
    step();
    idle(); step();
    check("t3_b_stall", b_stall, 3);
    check("t3_b_pc", b_pc, 1);

    // XZR, unused-operand and invalid-EX cases never stall.
    pulse_reset();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; step();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd4; id_r2 = 5'd4; id_uses_r2 = 1'b0; step();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; ex_valid = 1'b0; step();
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_r2 = 5'd31; id_rn = 5'd31; step();
    check("xzr_no_stall", {a_stall, b_stall}, 0);

    // Taken branch on the second stall cycle of B.
    pulse_reset();
    load_use_rn9(); step();
    idle(); step();
    idle(); mem_br_taken = 1'b1; step();
    idle(); step();
    check("t4_b_flush", b_flush, 1);
    check("t4_b_stall", b_stall, 2);

    // Branch coinciding with a load-use hazard: branch wins.
    pulse_reset();
    load_use_rn9(); mem_br_taken = 1'b1; step();
    idle(); step();

    // Busy for four cycles alongside a taken branch.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); dmem_busy = 1'b1; mem_br_taken = 1'b1; step();
    end
    idle(); mem_br_taken = 1'b1; step();
    idle(); step();
    check("t5_a_stall", a_stall, 4);
    check("t5_a_flush", a_flush, 1);

    // Reset in the middle of LU_WAIT, then a normal cycle.
    pulse_reset();
    load_use_rn9(); step();
    idle(); step();
    idle();
    pulse_reset();
    idle(); step();
    check("t6_b_pc", b_pc, 1);

    // Randomized traffic, small register range to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      id_rn        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      id_r2        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      id_uses_rn   = $urandom_range(0, 1);
      id_uses_r2   = $urandom_range(0, 1);
      ex_valid     = ($urandom_range(0, 7) != 0);
      ex_mem_read  = $urandom_range(0, 1);
      ex_rd        = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      mem_br_taken = ($urandom_range(0, 9) == 0);
      dmem_busy    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage LEGv8 core. It sits beside the decode stage and compares the register numbers being read in ID (rn and the muxed second read register) against an in-flight load in EX. It sequences the pipeline using PC/IF-ID write enables, an ID/EX bubble, a global hold for a slow data memory, and flushes for taken branches resolved in MEM. It also keeps saturating stall and flush performance counters.

Parameters:
REG_BITS, 5, width of register numbers
ZERO_REG, 31, register number of XZR; never a hazard source
LU_STALL, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  IF/ID holds a valid instruction
id_rn  input  REG_BITS  ID read register 1
id_r2  input  REG_BITS  ID read register 2, after the reg2_loc mux
id_uses_rn  input  1  ID instruction reads rn
id_uses_r2  input  1  ID instruction reads r2
ex_valid  input  1  ID/EX holds a valid instruction
ex_mem_read  input  1  EX instruction is a load (LDUR)
ex_rd  input  REG_BITS  EX destination register
mem_br_taken  input  1  branch in MEM resolved taken (CBZ taken or B)
dmem_busy  input  1  data memory not ready this cycle
pc_write  output  1  PC register load enable
ifid_write  output  1  IF/ID register load enable
idex_bubble  output  1  zero the control fields written into ID/EX
pipe_hold  output  1  hold ID/EX, EX/MEM and MEM/WB
ifid_flush  output  1  clear IF/ID valid
idex_flush  output  1  clear ID/EX valid
exmem_flush  output  1  clear EX/MEM valid
stall_cnt  output  CNT_W  cycles with pc_write=0
flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, stall counter=0, stall_cnt=0, flush_cnt=0.
  - All outputs are gated while in reset: pc_write=0, ifid_write=0, idex_bubble=0, pipe_hold=0, all flushes=0.
- lu_hit is combinational. It is 1 when all of these hold:
  - ex_valid & ex_mem_read & id_valid & ex_rd!=ZERO_REG
  - and either (id_uses_rn & id_rn==ex_rd) or (id_uses_r2 & id_r2==ex_rd).
- Outputs are Mealy (same-cycle) and evaluated in priority order:
  1. dmem_busy=1 (any state): pipe_hold=1, pc_write=0, ifid_write=0, idex_bubble=0, flushes=0. State and LU counter are frozen.
  2. mem_br_taken=1: ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1, idex_bubble=0. Next state=RUN and the LU counter is cleared. This overrides any pending load-use stall.
  3. State LU_WAIT: pc_write=0, ifid_write=0, idex_bubble=1. The counter decrements; the state returns to RUN when the counter reaches 0 this cycle.
  4. State RUN with lu_hit: pc_write=0, ifid_write=0, idex_bubble=1.
     - If LU_STALL>1: counter=LU_STALL-1, next state LU_WAIT.
     - Otherwise stay in RUN; the load advances to MEM, so lu_hit drops next cycle.
  5. Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- States: RUN and LU_WAIT only.
- stall_cnt increments on every cycle where pc_write=0 and rst_n=1, including dmem_busy cycles. It saturates at all-ones.
- flush_cnt increments on every cycle where priority case 2 fires. It saturates at all-ones.
- Boundaries:
  - Load to XZR never stalls.
  - Reads of XZR against a load to a non-XZR register never match.
  - ex_valid=0 suppresses lu_hit.
  - Simultaneous branch and lu_hit: branch wins, and the instruction in ID is flushed.
  - Simultaneous busy and branch: busy wins, and the branch is honoured on the first non-busy cycle.
  - Reset asserted in LU_WAIT returns to RUN immediately.

Test Plan:
- Load-use on rn: ex_mem_read=1, ex_rd=9, ex_valid=1, id_rn=9, id_uses_rn=1 for one cycle with LU_STALL=1 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_mem_read=0) pc_write=1; stall_cnt=1.
- XZR and unused-operand cases: ex_rd=31 with id_rn=31 -> no stall. ex_rd=4 with id_r2=4 but id_uses_r2=0 -> no stall.
- LU_STALL=3 with a single-cycle lu_hit -> idex_bubble=1 for exactly 3 consecutive cycles, then pc_write=1; stall_cnt=3.
- Taken branch during LU_WAIT (LU_STALL=3, branch on second stall cycle) -> all three flushes=1 and pc_write=1 that cycle; next cycle RUN with no bubble; flush_cnt=1.
- dmem_busy held 4 cycles concurrent with mem_br_taken=1 -> pipe_hold=1 and flushes=0 for 4 cycles; flush fires on cycle 5; stall_cnt=4, flush_cnt=1.
- rst_n pulsed low mid-LU_WAIT (asynchronous, between clock edges) -> outputs drop to the gated reset values immediately and counters read 0; after release, state is RUN and pc_write=1 on the next cycle.
